// File: rtl/cdm_pkg.sv
// Shared types and helpers for the sequential carry-disregard multiplier.
package cdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cdm_state_e;

    // Width of one slice partial product: WIDTH-bit multiplicand shifted by up to CHUNK-1.
    function automatic int unsigned cdm_pp_width(input int unsigned width, input int unsigned chunk);
        return width + chunk;
    endfunction

endpackage

// File: rtl/cdm_chunk_pp.sv
// Combinational WIDTH x CHUNK partial product, exact or carry-disregard in the low field.
module cdm_chunk_pp
    import cdm_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHUNK     = 4,
    parameter int unsigned DISREGARD = 4,
    localparam int unsigned PW       = cdm_pp_width(WIDTH, CHUNK)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [CHUNK-1:0] slice,
    input  logic             approx_en,
    output logic [PW-1:0]    pp_c
);

    localparam logic [PW-1:0] LOW_MASK = ~({PW{1'b1}} << DISREGARD);

    logic [PW-1:0] row;
    logic [PW-1:0] exact_sum;
    logic [PW-1:0] low_or;
    logic [PW-1:0] high_sum;

    // Sum the shifted rows exactly, and separately OR the low field while summing the rest.
    always_comb begin
        row       = '0;
        exact_sum = '0;
        low_or    = '0;
        high_sum  = '0;
        for (int j = 0; j < int'(CHUNK); j++) begin
            row       = PW'(a & {WIDTH{slice[j]}}) << j;
            exact_sum = exact_sum + row;
            low_or    = low_or | (row & LOW_MASK);
            high_sum  = high_sum + (row >> DISREGARD);
        end
        pp_c = approx_en ? ((high_sum << DISREGARD) | low_or) : exact_sum;
    end

endmodule

// File: rtl/cdm_seq_mul.sv
// Sequential carry-disregard approximate multiplier, one CHUNK-bit multiplier slice per cycle.
// Optional error statistics (err_dist, err_count) are built when CDM_ERR_STAT_EN is defined.
module cdm_seq_mul
    import cdm_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHUNK     = 4,
    parameter int unsigned DISREGARD = 4,
    localparam int unsigned NCHUNK   = WIDTH / CHUNK,
    localparam int unsigned AW       = $clog2(NCHUNK + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [AW-1:0]      approx_chunks,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
`ifdef CDM_ERR_STAT_EN
    ,
    output logic [2*WIDTH-1:0] err_dist,
    output logic [15:0]        err_count
`endif
);

    localparam int unsigned PW = cdm_pp_width(WIDTH, CHUNK);
    localparam int unsigned RW = 2 * WIDTH;

    cdm_state_e       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [AW-1:0]    napx_q;
    logic [AW-1:0]    idx;
    logic [RW-1:0]    acc;

    logic [CHUNK-1:0] slice_c;
    logic             approx_en_c;
    logic [PW-1:0]    pp_c;
    logic [RW-1:0]    acc_nxt_c;
    logic [AW-1:0]    napx_clamp_c;
    logic             last_c;

    // Select the current multiplier slice and form the next accumulator value.
    always_comb begin
        slice_c      = CHUNK'(b_q >> (idx * CHUNK));
        approx_en_c  = (idx < napx_q);
        acc_nxt_c    = acc + (RW'(pp_c) << (idx * CHUNK));
        last_c       = (idx == AW'(NCHUNK - 1));
        napx_clamp_c = (approx_chunks > AW'(NCHUNK)) ? AW'(NCHUNK) : approx_chunks;
    end

    cdm_chunk_pp #(
        .WIDTH     (WIDTH),
        .CHUNK     (CHUNK),
        .DISREGARD (DISREGARD)
    ) u_pp (
        .a         (a_q),
        .slice     (slice_c),
        .approx_en (approx_en_c),
        .pp_c      (pp_c)
    );

    // Control FSM with operand latch, accumulator and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            napx_q    <= '0;
            idx       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        napx_q   <= napx_clamp_c;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt_c;
                    idx <= idx + AW'(1);
                    if (last_c) begin
                        r         <= acc_nxt_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CDM_ERR_STAT_EN
    logic [RW-1:0] exact_c;

    // Exact reference product of the latched operands.
    always_comb begin
        exact_c = RW'(a_q) * RW'(b_q);
    end

    // Error distance captured with the result; count non-zero errors at each output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_dist  <= '0;
            err_count <= '0;
        end else begin
            if (state == RUN && last_c) begin
                err_dist <= exact_c - acc_nxt_c;
            end
            if (state == DONE && out_ready && err_dist != '0 && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdm_seq_mul.sv
// Self-checking bench for cdm_seq_mul (WIDTH=8, CHUNK=4, DISREGARD=4).
module tb_cdm_seq_mul;

    localparam int W   = 8;
    localparam int C   = 4;
    localparam int D   = 4;
    localparam int NCH = W / C;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [1:0]     approx_chunks = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] r;
`ifdef CDM_ERR_STAT_EN
    logic [2*W-1:0] err_dist;
    logic [15:0]    err_count;
    int             exp_err_count = 0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cdm_seq_mul #(.WIDTH(W), .CHUNK(C), .DISREGARD(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .approx_chunks (approx_chunks),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .r             (r)
`ifdef CDM_ERR_STAT_EN
        ,
        .err_dist      (err_dist),
        .err_count     (err_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: per-slice product from the row definitions, approximated for the low slices.
    function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb, input int n);
        longint total, ex, lo, hi, row, pp;
        int     nn;
        nn    = (n > NCH) ? NCH : n;
        total = 0;
        for (int s = 0; s < NCH; s++) begin
            ex = 0; lo = 0; hi = 0;
            for (int j = 0; j < C; j++) begin
                row = mb[s*C + j] ? (longint'(ma) << j) : 0;
                ex  = ex + row;
                lo  = lo | (row & ((64'd1 << D) - 1));
                hi  = hi + (row >> D);
            end
            pp    = (s < nn) ? ((hi << D) | lo) : ex;
            total = total + (pp << (s * C));
        end
        return 16'(total);
    endfunction

    // One full transaction; busy drives junk on in_valid while the block is occupied.
    task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tn,
                           input int hold, input bit busy, input logic [15:0] want);
        int          cnt;
        logic [15:0] exp_r;
        exp_r = model(ta, tb, int'(tn));
        check("model_vs_directed", 32'(exp_r), 32'(want));
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb; approx_chunks = tn; in_valid = 1'b1;
        @(posedge clk); #1;
        if (busy) begin
            a = ~ta; b = ~tb; approx_chunks = 2'd0;
        end else begin
            in_valid = 1'b0;
        end
        check("in_ready_busy", 32'(in_ready), 32'd0);
        check("out_valid_early", 32'(out_valid), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(NCH));
        check("r", 32'(r), 32'(exp_r));
`ifdef CDM_ERR_STAT_EN
        check("err_dist", 32'(err_dist), 32'(16'(int'(ta) * int'(tb)) - exp_r));
`endif
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_r", 32'(r), 32'(exp_r));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
`ifdef CDM_ERR_STAT_EN
        if (16'(int'(ta) * int'(tb)) != exp_r) exp_err_count++;
        check("err_count", 32'(err_count), 32'(exp_err_count));
`endif
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [1:0] rn;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Stray out_ready while idle does nothing.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stray_out_ready", 32'(out_valid), 32'd0);

        run_txn(8'hFF, 8'hFF, 2'd0, 0, 1'b0, 16'hFE01);
        run_txn(8'hFF, 8'h0F, 2'd2, 0, 1'b0, 16'h0ECF);
        run_txn(8'hFF, 8'hFF, 2'd1, 0, 1'b0, 16'hFDDF);
        run_txn(8'hFF, 8'hFF, 2'd0, 5, 1'b1, 16'hFE01);
        run_txn(8'h00, 8'hFF, 2'd3, 1, 1'b0, 16'h0000);
        run_txn(8'hFF, 8'hFF, 2'd3, 0, 1'b0, model(8'hFF, 8'hFF, 2));

        // Reset mid-RUN discards the transaction immediately.
        @(negedge clk);
        a = 8'hAB; b = 8'hCD; approx_chunks = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check("rst_run_out_valid", 32'(out_valid), 32'd0);
        check("rst_run_in_ready", 32'(in_ready), 32'd1);
        check("rst_run_r", 32'(r), 32'd0);
`ifdef CDM_ERR_STAT_EN
        check("rst_run_err_count", 32'(err_count), 32'd0);
        exp_err_count = 0;
`endif
        @(negedge clk); rst = 1'b0;
        run_txn(8'h03, 8'h05, 2'd0, 0, 1'b0, 16'h000F);

        // Reset while DONE.
        @(negedge clk);
        a = 8'h12; b = 8'h34; approx_chunks = 2'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (NCH) @(posedge clk);
        #1;
        check("done_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1; #1;
        check("rst_done_out_valid", 32'(out_valid), 32'd0);
        check("rst_done_r", 32'(r), 32'd0);
`ifdef CDM_ERR_STAT_EN
        exp_err_count = 0;
`endif
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rn = 2'($urandom_range(0, 3));
            run_txn(ra, rb, rn, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    model(ra, rb, int'(rn)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
